// File: rtl/ex_mul_sequencer.sv
// Multi-cycle EX-stage multiply: latches operands on a MUL in EX, stalls the
// pipeline while a radix-2^STEP_BITS shift-add runs, then pulses the product.
module ex_mul_sequencer #(
  parameter int DATA_W    = 32,
  parameter int STEP_BITS = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  input  logic              flush_i,
  input  logic [2:0]        alu_ctrl_i,
  input  logic [DATA_W-1:0] rs1_i,
  input  logic [DATA_W-1:0] rs2_i,
  output logic              stall_o,
  output logic              busy_o,
  output logic              result_valid_o,
  output logic [DATA_W-1:0] result_o,
  output logic [1:0]        state_o
);

  localparam int N_ITER = DATA_W / STEP_BITS;
  localparam int CNT_W  = $clog2(N_ITER + 1);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(N_ITER - 1);
  localparam logic [2:0] OP_MUL = 3'b010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state, state_next;
  logic [DATA_W-1:0] acc, mcand, mplier;
  logic [CNT_W-1:0]  iter_cnt;

  logic              start;
  logic [DATA_W-1:0] digit, acc_next, mplier_next;
  logic              last_iter;

  // Handshake: a MUL is accepted only in IDLE when valid_i is high and it is
  // not being flushed; stall_o is the backpressure that holds it in EX until
  // the single-cycle result_valid_o pulse, during which stall_o is low.
  assign start       = valid_i && (alu_ctrl_i == OP_MUL) && !flush_i;
  assign digit       = {{(DATA_W-STEP_BITS){1'b0}}, mplier[STEP_BITS-1:0]};
  assign acc_next    = acc + mcand * digit;
  assign mplier_next = mplier >> STEP_BITS;
  assign last_iter   = (mplier_next == '0) || (iter_cnt == LAST_ITER);

  always_comb begin
    state_next     = state;
    stall_o        = 1'b0;
    busy_o         = 1'b0;
    result_valid_o = 1'b0;
    case (state)
      IDLE: begin
        stall_o = start;
        if (start) state_next = BUSY;
      end
      BUSY: begin
        stall_o = 1'b1;
        busy_o  = 1'b1;
        if (flush_i)        state_next = IDLE;
        else if (last_iter) state_next = DONE;
      end
      DONE: begin
        // The finished MUL is still visible on the inputs; it must not restart.
        result_valid_o = 1'b1;
        state_next     = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state    <= IDLE;
      acc      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      iter_cnt <= '0;
      result_o <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (start) begin
            mcand    <= rs1_i;
            mplier   <= rs2_i;
            acc      <= '0;
            iter_cnt <= '0;
          end
        end
        BUSY: begin
          if (!flush_i) begin
            acc      <= acc_next;
            mcand    <= mcand << STEP_BITS;
            mplier   <= mplier_next;
            iter_cnt <= iter_cnt + 1'b1;
            if (last_iter) result_o <= acc_next;
          end
        end
        default: ;
      endcase
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_ex_mul_sequencer.sv
// Bench for ex_mul_sequencer: directed MUL vectors with literal expectations,
// plus a cycle-by-cycle reference model of stall/busy/valid/result.
module tb_ex_mul_sequencer;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        valid_i;
  logic        flush_i;
  logic [2:0]  alu_ctrl_i;
  logic [31:0] rs1_i, rs2_i;
  logic        stall_o, busy_o, result_valid_o;
  logic [31:0] result_o;
  logic [1:0]  state_o;

  int total = 0;
  int bad   = 0;

  ex_mul_sequencer #(.DATA_W(32), .STEP_BITS(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .flush_i(flush_i),
    .alu_ctrl_i(alu_ctrl_i), .rs1_i(rs1_i), .rs2_i(rs2_i),
    .stall_o(stall_o), .busy_o(busy_o), .result_valid_o(result_valid_o),
    .result_o(result_o), .state_o(state_o)
  );

  // clock / reset
  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int iter_count(input logic [31:0] b);
    int len = 0;
    for (int i = 0; i < 32; i++) if (b[i]) len = i + 1;
    return (len == 0) ? 1 : (len + 3) / 4;
  endfunction

  // Reference model: BUSY lasts iter_count(rs2) cycles, then one DONE cycle
  // exposing rs1*rs2 mod 2^32. Inputs are stable from posedge+1 to the next
  // posedge, so the model advances at the negedge using the current inputs.
  int          busy_left = 0;
  bit          done_now  = 1'b0;
  logic [31:0] m_res     = '0;
  logic [31:0] exp_q[$];

  always @(negedge clk_i) begin
    bit in_busy, start_c, exp_stall;
    in_busy   = (busy_left > 0);
    start_c   = valid_i && (alu_ctrl_i == 3'b010) && !flush_i;
    exp_stall = in_busy ? 1'b1 : (done_now ? 1'b0 : start_c);
    check("model_stall", {31'b0, stall_o}, {31'b0, exp_stall});
    check("model_busy", {31'b0, busy_o}, {31'b0, in_busy});
    check("model_valid", {31'b0, result_valid_o}, {31'b0, done_now});
    check("model_result", result_o, m_res);
    if (!rst_i) begin
      busy_left = 0;
      done_now  = 1'b0;
      m_res     = '0;
      exp_q.delete();
    end else if (in_busy) begin
      if (flush_i) begin
        busy_left = 0;
        exp_q.delete();
      end else begin
        busy_left--;
        if (busy_left == 0) begin
          done_now = 1'b1;
          m_res    = exp_q.pop_front();
        end
      end
    end else if (done_now) begin
      done_now = 1'b0;
    end else if (start_c) begin
      busy_left = iter_count(rs2_i);
      exp_q.push_back(rs1_i * rs2_i);
    end
  end

  // driver tasks
  task automatic go_idle();
    valid_i = 1'b0; flush_i = 1'b0; alu_ctrl_i = 3'b000;
  endtask

  task automatic step();
    @(posedge clk_i); #1;
  endtask

  task automatic run_mul(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_res, input int exp_stalls,
                         input string name);
    int stalls = 0;
    bit got = 1'b0;
    valid_i = 1'b1; flush_i = 1'b0; alu_ctrl_i = 3'b010; rs1_i = a; rs2_i = b;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk_i);
      if (stall_o) stalls++;
      if (result_valid_o) begin
        got = 1'b1;
        check({name, "_result"}, result_o, exp_res);
      end
    end
    if (!got) check({name, "_timeout"}, 32'd0, 32'd1);
    check({name, "_stall_cycles"}, stalls, exp_stalls);
    step();
  endtask

  initial begin
    rst_i = 1'b0; rs1_i = '0; rs2_i = '0;
    go_idle();
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b1;
    @(negedge clk_i);
    check("reset_stall", {31'b0, stall_o}, 32'd0);
    check("reset_busy", {31'b0, busy_o}, 32'd0);
    check("reset_valid", {31'b0, result_valid_o}, 32'd0);
    check("reset_result", result_o, 32'd0);
    check("reset_state", {30'b0, state_o}, 32'd0);
    step();

    // non-MUL and flushed MUL in IDLE must not start
    valid_i = 1'b1; alu_ctrl_i = 3'b000; rs1_i = 32'd3; rs2_i = 32'd3;
    step();
    alu_ctrl_i = 3'b010; flush_i = 1'b1;
    @(negedge clk_i);
    check("flushed_issue_stall", {31'b0, stall_o}, 32'd0);
    step();
    go_idle();
    step();

    run_mul(32'd6, 32'd7, 32'd42, 2, "small");
    go_idle(); step();
    run_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 9, "worst");
    go_idle(); step();
    run_mul(32'd123, 32'd0, 32'd0, 2, "zero_rs2");
    go_idle(); step();
    run_mul(32'h8000_0000, 32'd2, 32'd0, 2, "wrap");
    go_idle(); step();
    run_mul(32'h1234_5678, 32'h10, 32'h2345_6780, 3, "shift");
    go_idle(); step();

    run_mul(32'd3, 32'd5, 32'd15, 2, "b2b_first");
    run_mul(32'h1_0000, 32'h1_0000, 32'd0, 6, "b2b_second");
    go_idle();
    repeat (3) begin
      @(negedge clk_i);
      check("b2b_no_third", {31'b0, busy_o}, 32'd0);
      step();
    end

    // flush mid-BUSY: result must keep the prior product
    run_mul(32'd6, 32'd7, 32'd42, 2, "pre_flush");
    go_idle(); step();
    valid_i = 1'b1; alu_ctrl_i = 3'b010; rs1_i = 32'd5; rs2_i = 32'hFFFF_FFFF;
    step();
    go_idle();
    step();
    step();
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    @(negedge clk_i);
    check("flush_stall", {31'b0, stall_o}, 32'd0);
    check("flush_busy", {31'b0, busy_o}, 32'd0);
    check("flush_result_kept", result_o, 32'd42);
    repeat (10) begin
      @(negedge clk_i);
      check("flush_no_valid", {31'b0, result_valid_o}, 32'd0);
    end
    step();

    // reset mid-op
    valid_i = 1'b1; alu_ctrl_i = 3'b010; rs1_i = 32'hFFFF_FFFF; rs2_i = 32'hFFFF_FFFF;
    step();
    go_idle();
    step();
    rst_i = 1'b0;
    step();
    rst_i = 1'b1;
    @(negedge clk_i);
    check("midrst_stall", {31'b0, stall_o}, 32'd0);
    check("midrst_busy", {31'b0, busy_o}, 32'd0);
    check("midrst_valid", {31'b0, result_valid_o}, 32'd0);
    check("midrst_result", result_o, 32'd0);
    step();
    run_mul(32'd9, 32'd9, 32'd81, 2, "after_reset");
    go_idle();
    repeat (4) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ex_mul_sequencer.md
Name: ex_mul_sequencer

Overview:
- Multi-cycle sequencer for the EX-stage multiply operation (ALU control code 3'b010, OP_MUL). It takes multiply out of the single-cycle ALU path.
- Latches operands when a MUL instruction is in EX and stalls the pipeline while it runs an iterative radix-2^STEP_BITS shift-add multiply.
- Delivers the low DATA_W bits of the product with a one-cycle valid pulse. The EX result mux selects result_o whenever result_valid_o is high.

Parameters:
- DATA_W, 32: operand/result width.
- STEP_BITS, 4: multiplier bits consumed per iteration; DATA_W % STEP_BITS must be 0.
- N_ITER, DATA_W/STEP_BITS (8): maximum iterations (derived, not overridden).

Ports:
- clk_i  input  1  clock, all state updates on rising edge
- rst_i  input  1  synchronous, active-low reset
- valid_i  input  1  EX stage holds a valid instruction
- flush_i  input  1  EX instruction is being squashed (branch mispredict)
- alu_ctrl_i  input  3  ALU control code of EX instruction
- rs1_i  input  DATA_W  multiplicand (post-forwarding)
- rs2_i  input  DATA_W  multiplier (post-forwarding)
- stall_o  output  1  hold PC/IF/ID/EX; combinational from state and inputs
- busy_o  output  1  FSM in BUSY (registered-state decode)
- result_valid_o  output  1  result_o is the completed product this cycle
- result_o  output  DATA_W  product low bits, registered

Behaviour:
- Reset (rst_i==0 at a clock edge):
  - state=IDLE; acc, mcand, mplier, iter_cnt and result_o all cleared to 0.
  - stall_o, busy_o and result_valid_o are 0 while in IDLE after reset.
  - Reset has priority over every other event, including mid-BUSY; an aborted multiply produces no result_valid_o.
- start = valid_i & (alu_ctrl_i==3'b010) & ~flush_i, evaluated only in IDLE.
- IDLE:
  - stall_o = start.
  - On start: mcand<=rs1_i, mplier<=rs2_i, acc<=0, iter_cnt<=0, go to BUSY.
- BUSY:
  - stall_o=1, busy_o=1.
  - Each cycle: acc <= acc + mcand*mplier[STEP_BITS-1:0], truncated to DATA_W; mcand <= mcand<<STEP_BITS; mplier <= mplier>>STEP_BITS; iter_cnt++.
  - Go to DONE when the shifted mplier is 0 (early-out) or when iter_cnt==N_ITER-1 (hard bound); otherwise stay in BUSY.
  - On the exit cycle, result_o <= updated acc.
  - flush_i=1 in BUSY: abort to IDLE that edge. acc, mplier and result_o are left unchanged and result_valid_o is not pulsed. stall_o is still 1 in that cycle.
- DONE:
  - stall_o=0, result_valid_o=1 for exactly one cycle; pipeline advances past the MUL.
  - Next state is always IDLE. start is ignored in DONE (the same MUL is still visible on valid_i).
  - A new MUL in the following cycle starts normally, so back-to-back MULs are allowed.
- Arithmetic:
  - Unsigned shift-add. The low DATA_W bits equal the RISC-V MUL result for signed and unsigned operands alike.
  - All overflow bits are discarded.
- Latency:
  - Issue cycle T. Iterations k = max(1, ceil(bitlen(rs2)/STEP_BITS)).
  - DONE in cycle T+k+1; stall_o high for cycles T..T+k (k+1 cycles).
  - Worst case (N_ITER=8): 9 stall cycles.
- result_o holds its value from DONE until the next completed multiply; it changes only on a BUSY exit.
- Non-MUL alu_ctrl_i, or valid_i=0: no state change, stall_o=0.

Test Plan:
- Small multiply: rs1=6, rs2=7, MUL at T -> stall_o high T..T+1; DONE at T+2 with result_valid_o=1, result_o=42; stall_o=0 at T+2.
- Worst-case latency: rs1=0xFFFFFFFF, rs2=0xFFFFFFFF -> 8 iterations; stall_o high T..T+8; result_o=0x00000001 at T+9.
- Zero and wrap operands:
  - rs2=0 -> DONE at T+2, result_o=0.
  - rs1=0x80000000, rs2=2 -> result_o=0.
  - rs1=0x12345678, rs2=0x10 -> result_o=0x23456780.
- Back-to-back: 3*5 then 0x10000*0x10000 in consecutive instructions -> first result 15; second starts the cycle after DONE and returns 0 (overflow truncated). No spurious third start.
- Flush mid-BUSY: rs2=0xFFFFFFFF, flush_i at T+3 -> IDLE at T+4; result_valid_o never pulses; result_o keeps its prior value; stall_o=0 from T+4.
- Reset mid-op: rst_i=0 at T+2 of a long multiply -> next cycle IDLE with all outputs 0. A MUL issued afterwards (rs1=9, rs2=9) completes with result_o=81.
